// File: rtl/captura_operandos_n.sv
// rtl/captura_operandos_n.sv - keypad operand capture with decimal-to-binary conversion and ready/ack handoff
//
// Collects NUM_OPERANDS decimal operands of up to DIGITS digits each from debounced
// keypad strobes. Each operand is converted to binary as its digits arrive. Once every
// operand is closed, the block holds them stable and waits for the consumer's ack.
//
// Ports:
//   clk, rst        clock; synchronous active-high reset
//   tecla           key code, valid only while tecla_valida=1
//   tecla_valida    one-cycle key strobe
//   ack             consumer took the operands (only meaningful in DONE)
//   operands        packed operands, operand k at [k*OP_W +: OP_W]
//   ready_operands  all operands captured and stable
//   op_idx          index of the operand being entered
//   digit_cnt       digits entered in the current operand
//   cur_value       binary value of the operand in progress
//   key_ignored     one-cycle pulse: the strobed key had no effect
module captura_operandos_n #(
  parameter int         NUM_OPERANDS = 2,
  parameter int         DIGITS       = 2,
  parameter int         OP_W         = 7,
  parameter logic [3:0] KEY_ENTER    = 4'hA,
  parameter logic [3:0] KEY_BACK     = 4'hB,
  parameter logic [3:0] KEY_CLEAR    = 4'hC
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [3:0]                            tecla,
  input  logic                                  tecla_valida,
  input  logic                                  ack,
  output logic [NUM_OPERANDS*OP_W-1:0]          operands,
  output logic                                  ready_operands,
  output logic [$clog2(NUM_OPERANDS+1)-1:0]     op_idx,
  output logic [$clog2(DIGITS+1)-1:0]           digit_cnt,
  output logic [OP_W-1:0]                       cur_value,
  output logic                                  key_ignored
);

  localparam int IDX_W = $clog2(NUM_OPERANDS+1);
  localparam int CNT_W = $clog2(DIGITS+1);

  typedef enum logic {CAPTURE, DONE} state_t;

  state_t                       state_q, state_d;
  logic [NUM_OPERANDS*OP_W-1:0] ops_d;
  logic [IDX_W-1:0]             idx_d;
  logic [CNT_W-1:0]             cnt_d;
  logic [OP_W-1:0]              cur_d;
  logic                         ign_d;

  assign ready_operands = (state_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CAPTURE;
      operands    <= '0;
      op_idx      <= '0;
      digit_cnt   <= '0;
      cur_value   <= '0;
      key_ignored <= 1'b0;
    end else begin
      state_q     <= state_d;
      operands    <= ops_d;
      op_idx      <= idx_d;
      digit_cnt   <= cnt_d;
      cur_value   <= cur_d;
      key_ignored <= ign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ops_d   = operands;
    idx_d   = op_idx;
    cnt_d   = digit_cnt;
    cur_d   = cur_value;
    ign_d   = 1'b0;

    if (tecla_valida && tecla == KEY_CLEAR) begin
      // Clear wins in every state, including over a simultaneous ack.
      state_d = CAPTURE;
      ops_d   = '0;
      idx_d   = '0;
      cnt_d   = '0;
      cur_d   = '0;
    end else if (state_q == DONE) begin
      if (ack) begin
        state_d = CAPTURE;
        ops_d   = '0;
        idx_d   = '0;
        cnt_d   = '0;
        cur_d   = '0;
      end
      // Any non-clear key while operands are frozen is dropped, even alongside ack.
      if (tecla_valida) ign_d = 1'b1;
    end else if (tecla_valida) begin
      if (tecla == KEY_ENTER) begin
        for (int k = 0; k < NUM_OPERANDS; k++) begin
          if (op_idx == IDX_W'(k)) ops_d[k*OP_W +: OP_W] = cur_value;
        end
        cur_d = '0;
        cnt_d = '0;
        if (op_idx < IDX_W'(NUM_OPERANDS-1)) idx_d = op_idx + IDX_W'(1);
        else                                 state_d = DONE;
      end else if (tecla == KEY_BACK) begin
        if (digit_cnt != '0) begin
          cur_d = cur_value / OP_W'(10);
          cnt_d = digit_cnt - CNT_W'(1);
        end else begin
          ign_d = 1'b1;
        end
      end else if (tecla <= 4'd9) begin
        if (digit_cnt < CNT_W'(DIGITS)) begin
          // OP_W is sized so DIGITS digits never overflow; modular arithmetic at OP_W
          // gives the same low bits as a wider product.
          cur_d = cur_value * OP_W'(10) + OP_W'(tecla);
          cnt_d = digit_cnt + CNT_W'(1);
        end else begin
          ign_d = 1'b1;
        end
      end else begin
        ign_d = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_captura_operandos_n.sv
// tb/tb_captura_operandos_n.sv - self-checking bench for captura_operandos_n
module tb_captura_operandos_n;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  tecla = 4'h0;
  logic        tecla_valida = 1'b0;
  logic        ack = 1'b0;
  logic [13:0] operands;
  logic        ready_operands;
  logic [1:0]  op_idx;
  logic [1:0]  digit_cnt;
  logic [6:0]  cur_value;
  logic        key_ignored;

  logic [3:0]  tecla_b = 4'h0;
  logic        valida_b = 1'b0;
  logic        ack_b = 1'b0;
  logic [29:0] operands_b;
  logic        ready_b;
  logic [1:0]  op_idx_b;
  logic [1:0]  digit_cnt_b;
  logic [9:0]  cur_value_b;
  logic        ign_b;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: digits kept as a list, operands as integers.
  int m_ops[2];
  int m_digits[$];
  int m_idx;
  bit m_done;
  bit m_ign;

  always #5 clk = ~clk;

  captura_operandos_n dut_a (
    .clk(clk), .rst(rst), .tecla(tecla), .tecla_valida(tecla_valida), .ack(ack),
    .operands(operands), .ready_operands(ready_operands), .op_idx(op_idx),
    .digit_cnt(digit_cnt), .cur_value(cur_value), .key_ignored(key_ignored)
  );

  captura_operandos_n #(.NUM_OPERANDS(3), .DIGITS(3), .OP_W(10)) dut_b (
    .clk(clk), .rst(rst), .tecla(tecla_b), .tecla_valida(valida_b), .ack(ack_b),
    .operands(operands_b), .ready_operands(ready_b), .op_idx(op_idx_b),
    .digit_cnt(digit_cnt_b), .cur_value(cur_value_b), .key_ignored(ign_b)
  );

  function automatic int digits_value();
    int v = 0;
    foreach (m_digits[i]) v = v * 10 + m_digits[i];
    return v;
  endfunction

  function automatic logic [26:0] exp_vec();
    logic [13:0] ops;
    ops = {7'(m_ops[1]), 7'(m_ops[0])};
    return {ops, m_done, 2'(m_idx), 2'(m_digits.size()), 7'(digits_value()), m_ign};
  endfunction

  task automatic model_clear();
    m_ops[0] = 0; m_ops[1] = 0;
    m_digits.delete();
    m_idx = 0;
    m_done = 1'b0;
  endtask

  task automatic model_step(input bit v, input int k, input bit a);
    m_ign = 1'b0;
    if (v && k == 12) begin
      model_clear();
    end else if (m_done) begin
      if (v) m_ign = 1'b1;
      if (a) model_clear();
    end else if (v) begin
      if (k == 10) begin
        m_ops[m_idx] = digits_value();
        m_digits.delete();
        if (m_idx < 1) m_idx++;
        else m_done = 1'b1;
      end else if (k == 11) begin
        if (m_digits.size() > 0) void'(m_digits.pop_back());
        else m_ign = 1'b1;
      end else if (k <= 9) begin
        if (m_digits.size() < 2) m_digits.push_back(k);
        else m_ign = 1'b1;
      end else begin
        m_ign = 1'b1;
      end
    end
  endtask

  task automatic drive(input bit v, input int k, input bit a);
    @(negedge clk);
    tecla = 4'(k);
    tecla_valida = v;
    ack = a;
    @(posedge clk);
    model_step(v, k, a);
    #1;
    tecla_valida = 1'b0;
    ack = 1'b0;
  endtask

  task automatic press(input int k);
    drive(1'b1, k, 1'b0);
  endtask

  task automatic press_b(input int k);
    @(negedge clk);
    tecla_b = 4'(k);
    valida_b = 1'b1;
    @(posedge clk);
    #1;
    valida_b = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    m_ign = 1'b0;
    vectors++;
    if ({operands, ready_operands, op_idx, digit_cnt, cur_value, key_ignored} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_a: got %h want 0",
               {operands, ready_operands, op_idx, digit_cnt, cur_value, key_ignored});
    end
    vectors++;
    if ({operands_b, ready_b, op_idx_b, digit_cnt_b, cur_value_b, ign_b} !== 46'd0) begin
      miscompares++;
      $display("FAIL reset_b: got %h want 0",
               {operands_b, ready_b, op_idx_b, digit_cnt_b, cur_value_b, ign_b});
    end
  endtask

  task automatic test_defaults();
    press(4); press(5); press(10); press(2); press(3);
    vectors++;
    if (ready_operands !== 1'b0) begin
      miscompares++; $display("FAIL defaults_not_ready: got %b want 0", ready_operands);
    end
    press(10);
    vectors++;
    if (ready_operands !== 1'b1 || operands[6:0] !== 7'd45 || operands[13:7] !== 7'd23) begin
      miscompares++;
      $display("FAIL defaults_ops: got ready=%b op0=%0d op1=%0d want 1/45/23",
               ready_operands, operands[6:0], operands[13:7]);
    end
    press(12);
  endtask

  task automatic test_backspace();
    press(7); press(9); press(11); press(8); press(10);
    vectors++;
    if (operands[6:0] !== 7'd78 || digit_cnt !== 2'd0 || op_idx !== 2'd1) begin
      miscompares++;
      $display("FAIL backspace_op0: got op0=%0d cnt=%0d idx=%0d want 78/0/1",
               operands[6:0], digit_cnt, op_idx);
    end
    press(11);
    vectors++;
    if (key_ignored !== 1'b1 || op_idx !== 2'd1 || operands[6:0] !== 7'd78) begin
      miscompares++;
      $display("FAIL backspace_empty: got ign=%b idx=%0d op0=%0d want 1/1/78",
               key_ignored, op_idx, operands[6:0]);
    end
    drive(1'b0, 0, 1'b0);
    vectors++;
    if (key_ignored !== 1'b0) begin
      miscompares++; $display("FAIL ignored_pulse_width: got %b want 0", key_ignored);
    end
    press(12);
  endtask

  task automatic test_overflow_empty();
    press(1); press(2); press(3);
    vectors++;
    if (key_ignored !== 1'b1 || cur_value !== 7'd12 || digit_cnt !== 2'd2) begin
      miscompares++;
      $display("FAIL overflow_digit: got ign=%b cur=%0d cnt=%0d want 1/12/2",
               key_ignored, cur_value, digit_cnt);
    end
    press(10); press(10);
    vectors++;
    if (operands !== {7'd0, 7'd12} || ready_operands !== 1'b1 || op_idx !== 2'd1) begin
      miscompares++;
      $display("FAIL empty_operand: got ops=%h ready=%b idx=%0d want %h/1/1",
               operands, ready_operands, op_idx, {7'd0, 7'd12});
    end
  endtask

  task automatic test_handshake();
    press(5);
    vectors++;
    if (key_ignored !== 1'b1 || operands !== {7'd0, 7'd12} || ready_operands !== 1'b1 ||
        cur_value !== 7'd0) begin
      miscompares++;
      $display("FAIL done_key: got ign=%b ops=%h ready=%b cur=%0d want 1/%h/1/0",
               key_ignored, operands, ready_operands, cur_value, {7'd0, 7'd12});
    end
    drive(1'b0, 0, 1'b1);
    vectors++;
    if (ready_operands !== 1'b0 || op_idx !== 2'd0 || operands !== 14'd0) begin
      miscompares++;
      $display("FAIL ack: got ready=%b idx=%0d ops=%h want 0/0/0", ready_operands, op_idx, operands);
    end
    drive(1'b0, 0, 1'b1);
    vectors++;
    if (ready_operands !== 1'b0 || op_idx !== 2'd0 || key_ignored !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_in_capture: got ready=%b idx=%0d ign=%b want 0/0/0",
               ready_operands, op_idx, key_ignored);
    end
    press(6); press(10); press(9); press(10);
    drive(1'b1, 3, 1'b1);
    vectors++;
    if (ready_operands !== 1'b0 || key_ignored !== 1'b1 || operands !== 14'd0 ||
        digit_cnt !== 2'd0) begin
      miscompares++;
      $display("FAIL ack_with_key: got ready=%b ign=%b ops=%h cnt=%0d want 0/1/0/0",
               ready_operands, key_ignored, operands, digit_cnt);
    end
  endtask

  task automatic test_clear_reset();
    press(4); press(10); press(12);
    vectors++;
    if ({operands, ready_operands, op_idx, digit_cnt, cur_value, key_ignored} !== 27'd0) begin
      miscompares++;
      $display("FAIL clear: got %h want 0",
               {operands, ready_operands, op_idx, digit_cnt, cur_value, key_ignored});
    end
    press(3); press(10); press(7);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    m_ign = 1'b0;
    vectors++;
    if ({operands, ready_operands, op_idx, digit_cnt, cur_value, key_ignored} !== 27'd0) begin
      miscompares++;
      $display("FAIL reset_mid_entry: got %h want 0",
               {operands, ready_operands, op_idx, digit_cnt, cur_value, key_ignored});
    end
  endtask

  task automatic test_param3();
    int keys[10] = '{9, 9, 9, 10, 1, 10, 2, 5, 0, 10};
    foreach (keys[i]) press_b(keys[i]);
    vectors++;
    if (operands_b !== {10'd250, 10'd1, 10'd999} || ready_b !== 1'b1 || op_idx_b !== 2'd2) begin
      miscompares++;
      $display("FAIL param3: got ops=%h ready=%b idx=%0d want %h/1/2",
               operands_b, ready_b, op_idx_b, {10'd250, 10'd1, 10'd999});
    end
  endtask

  task automatic test_random();
    int r, k;
    bit v, a;
    logic [26:0] got, want;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 19);
      if (r < 12)      k = $urandom_range(0, 9);
      else if (r < 15) k = 10;
      else if (r < 17) k = 11;
      else if (r < 18) k = 12;
      else             k = $urandom_range(13, 15);
      v = ($urandom_range(0, 9) < 7);
      a = ($urandom_range(0, 3) == 0);
      drive(v, k, a);
      got  = {operands, ready_operands, op_idx, digit_cnt, cur_value, key_ignored};
      want = exp_vec();
      vectors++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL random[%0d] v=%b k=%h ack=%b: got %h want %h", n, v, k, a, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_backspace();
    test_overflow_empty();
    test_handshake();
    test_clear_reset();
    test_param3();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
